pc_ifid_stage: RTL and testbench

- Sequential stage directly downstream of the 32-bit 2:1 next-PC select mux. The mux chooses between PC+4 and the branch/jump target.
- Holds the program counter register, which drives instruction memory.
- Captures the fetched instruction into the IF/ID pipeline register for the decode stage.
- Implements hazard-unit stall and branch-redirect flush, with a one-cycle misalignment flag.

---
 rtl/pc_ifid_stage_if.sv | 28 ++
 rtl/pc_ifid_stage.sv | 87 ++++++++
 tb/tb_pc_ifid_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pc_ifid_stage_if.sv
// Bundle between the fetch-side control (next-PC mux, hazard unit, branch
// resolution, instruction memory) and the PC / IF-ID register stage.
interface pc_ifid_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] next_pc;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_pc_plus4;
    logic [XLEN-1:0] ifid_instr;
    logic            ifid_valid;
    logic            misalign;

    // Fetch-side control: drives the redirect/hazard inputs and the memory data.
    modport master (
        output next_pc, stall, flush, instr_in,
        input  pc, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid, misalign
    );

    // The register stage itself.
    modport slave (
        input  next_pc, stall, flush, instr_in,
        output pc, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid, misalign
    );
endinterface

// File: rtl/pc_ifid_stage.sv
// Program counter plus IF/ID pipeline register with hazard stall, branch-redirect
// flush and a one-cycle flag for misaligned next-PC loads. All outputs are registered.
module pc_ifid_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    pc_ifid_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        UPD_NORMAL,
        UPD_STALL,
        UPD_FLUSH
    } upd_e;

    upd_e            w_upd;
    logic [XLEN-1:0] w_next_pc_aligned;
    logic            w_next_misalign;
    logic [XLEN-1:0] w_pc_plus4;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_pc_plus4;
    logic [XLEN-1:0] r_ifid_instr;
    logic            r_ifid_valid;
    logic            r_misalign;

    // Flush outranks stall: a redirect must not be frozen behind a hazard.
    // NOTE: w_upd gets a default first so no path through this block infers a latch.
    always_comb begin
        w_upd = UPD_NORMAL;
        if (bus.flush) begin
            w_upd = UPD_FLUSH;
        end else if (bus.stall) begin
            w_upd = UPD_STALL;
        end
    end

    assign w_next_pc_aligned = {bus.next_pc[XLEN-1:2], 2'b00};
    assign w_next_misalign   = |bus.next_pc[1:0];
    assign w_pc_plus4        = r_pc + XLEN'(4);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus4 <= '0;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_valid    <= 1'b0;
            r_misalign      <= 1'b0;
        end else begin
            case (w_upd)
                UPD_FLUSH: begin
                    r_pc            <= w_next_pc_aligned;
                    r_ifid_pc       <= '0;
                    r_ifid_pc_plus4 <= '0;
                    r_ifid_instr    <= NOP_INSTR;
                    r_ifid_valid    <= 1'b0;
                    r_misalign      <= w_next_misalign;
                end
                UPD_STALL: begin
                    r_misalign      <= 1'b0;
                end
                default: begin
                    r_pc            <= w_next_pc_aligned;
                    r_ifid_pc       <= r_pc;
                    r_ifid_pc_plus4 <= w_pc_plus4;
                    r_ifid_instr    <= bus.instr_in;
                    r_ifid_valid    <= 1'b1;
                    r_misalign      <= w_next_misalign;
                end
            endcase
        end
    end

    assign bus.pc            = r_pc;
    assign bus.ifid_pc       = r_ifid_pc;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.misalign      = r_misalign;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Directed scenarios followed by randomized traffic, all outputs compared each
// cycle against a cycle-level reference model of the PC / IF-ID stage.
module tb_pc_ifid_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk;
    logic rst;

    pc_ifid_stage_if #(.XLEN(32)) bus ();

    pc_ifid_stage #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_pc, m_ifid_pc, m_ifid_pc_plus4, m_ifid_instr;
    logic        m_ifid_valid, m_misalign;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign bus.instr_in = mem_word(bus.pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h expected=%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},         bus.pc,            m_pc);
        check({tag, ".ifid_pc"},    bus.ifid_pc,       m_ifid_pc);
        check({tag, ".ifid_pc4"},   bus.ifid_pc_plus4, m_ifid_pc_plus4);
        check({tag, ".ifid_instr"}, bus.ifid_instr,    m_ifid_instr);
        check({tag, ".ifid_valid"}, 32'(bus.ifid_valid), 32'(m_ifid_valid));
        check({tag, ".misalign"},   32'(bus.misalign),   32'(m_misalign));
    endtask

    // Apply one cycle of inputs, advance the model by the stage's rules, compare.
    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic [31:0] np);
        logic [31:0] aligned;
        rst         = r;
        bus.stall   = s;
        bus.flush   = f;
        bus.next_pc = np;
        @(posedge clk);
        aligned = np & 32'hFFFF_FFFC;
        if (r) begin
            m_pc = RESET_PC; m_ifid_pc = 0; m_ifid_pc_plus4 = 0;
            m_ifid_instr = NOP_INSTR; m_ifid_valid = 0; m_misalign = 0;
        end else if (f) begin
            m_ifid_pc = 0; m_ifid_pc_plus4 = 0;
            m_ifid_instr = NOP_INSTR; m_ifid_valid = 0;
            m_misalign = (np[1:0] != 2'b00);
            m_pc = aligned;
        end else if (s) begin
            m_misalign = 0;
        end else begin
            m_ifid_pc       = m_pc;
            m_ifid_pc_plus4 = m_pc + 32'd4;
            m_ifid_instr    = mem_word(m_pc);
            m_ifid_valid    = 1;
            m_misalign      = (np[1:0] != 2'b00);
            m_pc            = aligned;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] np;
        logic        r, s, f;
        rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.next_pc = '0;
        m_pc = '0; m_ifid_pc = '0; m_ifid_pc_plus4 = '0;
        m_ifid_instr = '0; m_ifid_valid = 1'b0; m_misalign = 1'b0;

        // Reset for two cycles, then sequential fetch.
        step("rst0", 1, 0, 0, 32'h0);
        step("rst1", 1, 0, 0, 32'h0);
        check("rst.pc",    bus.pc, 32'h0);
        check("rst.valid", 32'(bus.ifid_valid), 32'h0);
        check("rst.instr", bus.ifid_instr, 32'h0000_0013);
        step("run1", 0, 0, 0, m_pc + 32'd4);
        check("run1.pc",      bus.pc, 32'h4);
        check("run1.ifid_pc", bus.ifid_pc, 32'h0);
        check("run1.valid",   32'(bus.ifid_valid), 32'h1);
        step("run2", 0, 0, 0, m_pc + 32'd4);
        check("run2.pc",    bus.pc, 32'h8);
        check("run2.pc4",   bus.ifid_pc_plus4, 32'h8);
        check("run2.instr", bus.ifid_instr, mem_word(32'h4));
        step("run3", 0, 0, 0, m_pc + 32'd4);
        step("run4", 0, 0, 0, m_pc + 32'd4);
        check("pre_stall.pc",      bus.pc, 32'h10);
        check("pre_stall.ifid_pc", bus.ifid_pc, 32'hC);

        // Three-cycle stall with a different next_pc presented; everything holds.
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 1, 0, 32'h0000_0ABC);
            check("stall.pc",      bus.pc, 32'h10);
            check("stall.ifid_pc", bus.ifid_pc, 32'hC);
        end
        step("unstall", 0, 0, 0, 32'h14);
        check("unstall.pc",      bus.pc, 32'h14);
        check("unstall.ifid_pc", bus.ifid_pc, 32'h10);
        check("unstall.instr",   bus.ifid_instr, mem_word(32'h10));

        // Flush while stalled: redirect wins.
        step("flush", 0, 1, 1, 32'h100);
        check("flush.pc",    bus.pc, 32'h100);
        check("flush.valid", 32'(bus.ifid_valid), 32'h0);
        check("flush.instr", bus.ifid_instr, 32'h0000_0013);
        step("post_flush", 0, 0, 0, 32'h104);
        check("post_flush.ifid_pc", bus.ifid_pc, 32'h100);
        check("post_flush.valid",   32'(bus.ifid_valid), 32'h1);

        // Misaligned target: aligned load and a single-cycle flag.
        step("mis", 0, 0, 0, 32'h202);
        check("mis.pc",  bus.pc, 32'h200);
        check("mis.flg", 32'(bus.misalign), 32'h1);
        step("mis_after", 0, 0, 0, 32'h204);
        check("mis_after.flg", 32'(bus.misalign), 32'h0);

        // Reset while stall and flush are both asserted.
        step("to40", 0, 0, 0, 32'h40);
        check("to40.pc", bus.pc, 32'h40);
        step("rst_mid", 1, 1, 1, 32'h83);
        check("rst_mid.pc",    bus.pc, RESET_PC);
        check("rst_mid.valid", 32'(bus.ifid_valid), 32'h0);
        check("rst_mid.mis",   32'(bus.misalign), 32'h0);

        // PC+4 wrap at the top of the address space.
        step("to_top", 0, 0, 0, 32'hFFFF_FFFC);
        step("wrap",   0, 0, 0, 32'h0);
        check("wrap.pc4", bus.ifid_pc_plus4, 32'h0);
        check("wrap.pc",  bus.pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0, 1:    np = $urandom;
                2:       np = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: np = m_pc + 32'd4 + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
            endcase
            step("rand", r, s, f, np);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
